// File: rtl/bank.sv
// rtl/bank.sv - single DRAM bank storage array with registered read port
// Stores one DEVICE_WIDTH cell per {row, column}; reads return one clock later.
module bank #(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_o_wr,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  input  logic [CHWIDTH-1:0]      row,
  input  logic [COLWIDTH-1:0]     column
);

  localparam int ADDR_W = CHWIDTH + COLWIDTH;
  localparam int DEPTH  = 1 << ADDR_W;

  // Array contents survive reset, so the zero power-up state comes from the declaration.
  logic [DEVICE_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DEVICE_WIDTH-1:0] r_dqout;
  logic [ADDR_W-1:0]       w_addr;

  assign w_addr = {row, column};

  always_ff @(posedge clk) begin
    if (!rst && rd_o_wr) begin
      r_mem[w_addr] <= dqin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dqout <= '0;
    end else if (!rd_o_wr) begin
      r_dqout <= r_mem[w_addr];
    end
  end

  assign dqout = r_dqout;

endmodule

// File: tb/tb_bank.sv
// tb/tb_bank.sv - directed and randomized checks of bank against a sparse storage model
// Model keeps written cells in an associative array; absent entries read as zero.
module tb_bank;

  logic       clk;
  logic       rst;
  logic       rd_o_wr;
  logic [3:0] dqin;
  logic [3:0] dqout;
  logic [4:0] row;
  logic [9:0] column;

  int checks = 0;
  int errors = 0;

  logic [3:0] model [int];
  logic [3:0] exp_dq;

  bank #(.DEVICE_WIDTH(4), .COLWIDTH(10), .CHWIDTH(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_o_wr (rd_o_wr),
    .dqin    (dqin),
    .dqout   (dqout),
    .row     (row),
    .column  (column)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_rd(input logic [4:0] r, input logic [9:0] c);
    int key;
    key = int'(r) * 1024 + int'(c);
    if (model.exists(key)) return model[key];
    return 4'h0;
  endfunction

  // Present one operation, take one edge, update the model and check dqout.
  task automatic step(input string tag, input logic wr, input logic [4:0] r,
                      input logic [9:0] c, input logic [3:0] d);
    rd_o_wr = wr;
    row     = r;
    column  = c;
    dqin    = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (wr) model[int'(r) * 1024 + int'(c)] = d;
      else    exp_dq = model_rd(r, c);
    end
    check(tag, dqout, exp_dq);
  endtask

  logic [3:0] burst [8];

  initial begin
    burst = '{4'h4, 4'h1, 4'h9, 4'h3, 4'hD, 4'hD, 4'h5, 4'h2};
    rst = 1'b1; rd_o_wr = 1'b0; dqin = '0; row = '0; column = '0;
    exp_dq = 4'h0;
    #12;
    check("reset_dqout", dqout, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    step("init_read_0_0", 1'b0, 5'd0, 10'd0, 4'h0);

    for (int i = 0; i < 8; i++) step("burst_wr", 1'b1, 5'd1, 10'(i), burst[i]);
    for (int i = 0; i < 8; i++) begin
      step("burst_rd", 1'b0, 5'd1, 10'(i), 4'h0);
      check("burst_rd_const", dqout, burst[i]);
    end

    step("hold_rd", 1'b0, 5'd1, 10'd0, 4'h0);
    check("hold_rd_const", dqout, 4'h4);
    step("hold_wr", 1'b1, 5'd2, 10'd0, 4'hF);
    check("hold_wr_const", dqout, 4'h4);
    step("hold_rdback", 1'b0, 5'd2, 10'd0, 4'h0);
    check("hold_rdback_const", dqout, 4'hF);

    step("corner_wr_a", 1'b1, 5'd0, 10'd5, 4'hA);
    step("corner_wr_b", 1'b1, 5'd31, 10'd1023, 4'h7);
    step("iso_r1c5", 1'b0, 5'd1, 10'd5, 4'h0);
    check("iso_r1c5_const", dqout, 4'hD);
    step("iso_r0c5", 1'b0, 5'd0, 10'd5, 4'h0);
    check("iso_r0c5_const", dqout, 4'hA);
    step("iso_r31c1023", 1'b0, 5'd31, 10'd1023, 4'h0);
    check("iso_r31c1023_const", dqout, 4'h7);

    // Asynchronous reset pulse between edges, with a write presented while held.
    #2;
    rst = 1'b1;
    #1;
    exp_dq = 4'h0;
    check("rst_async_clear", dqout, 4'h0);
    step("rst_drop_wr", 1'b1, 5'd3, 10'd3, 4'hC);
    @(negedge clk);
    rst = 1'b0;
    step("rst_dropped_cell", 1'b0, 5'd3, 10'd3, 4'h0);
    check("rst_dropped_const", dqout, 4'h0);
    step("rst_kept_cell", 1'b0, 5'd1, 10'd0, 4'h0);
    check("rst_kept_const", dqout, 4'h4);

    // Random traffic on a small address window so reads hit written cells.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r;
      logic [9:0] c;
      if ($urandom_range(0, 9) == 0) begin
        r = 5'($urandom);
        c = 10'($urandom);
      end else begin
        r = 5'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 5'd28 : 5'd0);
        c = 10'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 10'd1016 : 10'd0);
      end
      step("rand_op", 1'($urandom_range(0, 1)), r, c, 4'($urandom));
    end

    // Full read-back sweep of the window the random phase touched.
    for (int rr = 0; rr < 32; rr += 28) begin
      for (int dr = 0; dr < 4; dr++) begin
        for (int cc = 0; cc < 1024; cc += 1016) begin
          for (int dc = 0; dc < 8; dc++) begin
            step("sweep_rd", 1'b0, 5'(rr + dr), 10'(cc + dc), 4'h0);
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
